// File: rtl/program_memory_pkg.sv
// ---------------------------------------------------------------------------
// program_memory_pkg : FSM encodings and fixed instruction words | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef NOP
`define NOP 4'h0
`endif
`ifndef LED
`define LED 4'h9
`endif

package program_memory_pkg;

  localparam logic [1:0] PM_IDLE = 2'd0;
  localparam logic [1:0] PM_LOAD = 2'd1;
  localparam logic [1:0] PM_RUN  = 2'd2;

  localparam logic [27:0] PM_NOP_WORD     = {`NOP, 24'd4000};
  localparam logic [27:0] PM_DEFAULT_WORD = {`LED, 24'b10101010};

  // Where the registered instruction output is currently sourced from
  typedef enum logic [1:0] {
    SRC_NOP     = 2'd0,
    SRC_RAM     = 2'd1,
    SRC_DEFAULT = 2'd2
  } fetch_src_t;

endpackage

`default_nettype wire

// File: rtl/program_memory_if.sv
// ---------------------------------------------------------------------------
// program_memory_if : load stream + fetch port bundle | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface program_memory_if #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 16
);

  logic                  load_start;
  logic [ADDR_WIDTH-1:0] load_count;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_done;
  logic                  fetch_enable;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  instruction_valid;
  logic [ADDR_WIDTH:0]   program_length;

  modport master (
    output load_start, load_count, load_valid, load_data, fetch_enable, address,
    input  load_ready, load_done, instruction, instruction_valid, program_length
  );

  modport slave (
    input  load_start, load_count, load_valid, load_data, fetch_enable, address,
    output load_ready, load_done, instruction, instruction_valid, program_length
  );

endinterface

`default_nettype wire

// File: rtl/program_memory_array.sv
// ---------------------------------------------------------------------------
// program_memory_array : single-port synchronous RAM, registered read | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module program_memory_array #(
  parameter int DATA_WIDTH = 28,
  parameter int DEPTH      = 256,
  parameter int AW         = 8
) (
  input  wire logic                  clk,
  input  wire logic                  i_we,
  input  wire logic                  i_re,
  input  wire logic [AW-1:0]         i_addr,
  input  wire logic [DATA_WIDTH-1:0] i_wdata,
  output logic      [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // No reset on purpose: keeps the array and read register block-RAM inferable
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/program_memory.sv
// ---------------------------------------------------------------------------
// program_memory : loadable program store with gated registered fetch | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module program_memory
  import program_memory_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 256,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD     = DATA_WIDTH'(PM_NOP_WORD),
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(PM_DEFAULT_WORD)
) (
  input wire logic   clk,
  input wire logic   rst_n,
  program_memory_if.slave bus
);

  localparam int                  AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_ONE   = (ADDR_WIDTH+1)'(1);

  generate
    if ((DEPTH < 1) || (DEPTH > (1 << ADDR_WIDTH)) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("program_memory: DEPTH must be a power of two no larger than 2**ADDR_WIDTH");
    end
  endgenerate

  logic [1:0]            r_state;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic [ADDR_WIDTH:0]   r_target;
  logic [ADDR_WIDTH:0]   r_length;
  logic                  r_done;
  logic                  r_valid;
  fetch_src_t            r_src;

  logic                  w_ready;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_start;
  logic                  w_fetch;
  logic                  w_in_range;
  logic [ADDR_WIDTH:0]   w_count;
  logic [ADDR_WIDTH:0]   w_target;
  logic [AW-1:0]         w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic [DATA_WIDTH-1:0] w_instruction;

  assign w_ready    = (r_state == PM_LOAD);
  assign w_beat     = w_ready & bus.load_valid;
  assign w_last     = w_beat && (r_ptr == (r_target - C_ONE));
  assign w_start    = bus.load_start && (bus.load_count != '0) && (r_state != PM_LOAD);
  assign w_count    = {1'b0, bus.load_count};
  assign w_target   = (w_count > C_DEPTH) ? C_DEPTH : w_count;

  // Full-width compare: length never exceeds DEPTH, so any high address bit
  // lands in the default case instead of aliasing into the array
  assign w_in_range = ({1'b0, bus.address} < r_length);
  assign w_fetch    = (r_state == PM_RUN) && bus.fetch_enable && !w_start;
  assign w_ram_addr = w_beat ? r_ptr[AW-1:0] : bus.address[AW-1:0];

  program_memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_beat),
    .i_re    (w_fetch && w_in_range),
    .i_addr  (w_ram_addr),
    .i_wdata (bus.load_data),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= PM_IDLE;
      r_ptr    <= '0;
      r_target <= '0;
      r_length <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      case (r_state)
        PM_IDLE, PM_RUN: begin
          if (w_start) begin
            r_state  <= PM_LOAD;
            r_ptr    <= '0;
            r_length <= '0;
            r_target <= w_target;
          end
        end
        PM_LOAD: begin
          if (w_beat) begin
            r_ptr    <= r_ptr + C_ONE;
            r_length <= r_ptr + C_ONE;
            if (w_last) begin
              r_state <= PM_RUN;
            end
          end
        end
        default: r_state <= PM_IDLE;
      endcase
    end
  end

  // The RAM read register only updates on in-range fetches, so holding r_src
  // also holds the presented word when fetch is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src   <= SRC_NOP;
      r_valid <= 1'b0;
    end else if ((r_state != PM_RUN) || w_start) begin
      r_src   <= SRC_NOP;
      r_valid <= 1'b0;
    end else if (bus.fetch_enable) begin
      r_src   <= w_in_range ? SRC_RAM : SRC_DEFAULT;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  always_comb begin
    w_instruction = NOP_WORD;
    case (r_src)
      SRC_RAM:     w_instruction = w_ram_rdata;
      SRC_DEFAULT: w_instruction = DEFAULT_WORD;
      default:     w_instruction = NOP_WORD;
    endcase
  end

  assign bus.load_ready        = w_ready;
  assign bus.load_done         = r_done;
  assign bus.instruction       = w_instruction;
  assign bus.instruction_valid = r_valid;
  assign bus.program_length    = r_length;

endmodule

`default_nettype wire

// File: tb/tb_program_memory.sv
// ---------------------------------------------------------------------------
// tb_program_memory : directed scoreboard bench for program_memory | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_program_memory;
  import program_memory_pkg::*;

  localparam int DW    = 28;
  localparam int AW    = 16;
  localparam int DEPTH = 256;
  localparam logic [DW-1:0] NOP_W = {`NOP, 24'd4000};
  localparam logic [DW-1:0] DEF_W = {`LED, 24'b10101010};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  program_memory #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] instr;
    logic          valid;
  } fetch_exp_t;

  fetch_exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic en, input logic [AW-1:0] a,
                       input logic [DW-1:0] ei, input logic ev, input string tag);
    fetch_exp_t e;
    bus.fetch_enable = en;
    bus.address      = a;
    e.instr = ei;
    e.valid = ev;
    sb.push_back(e);
    step();
    e = sb.pop_front();
    check({tag, "_instr"}, 32'(bus.instruction), 32'(e.instr));
    check({tag, "_valid"}, 32'(bus.instruction_valid), 32'(e.valid));
    bus.fetch_enable = 1'b0;
  endtask

  // gap_after<0 means no gap; fetch_too drives a fetch alongside load_start
  task automatic load(input int count_req, input int n_beats, input logic [DW-1:0] base,
                      input int gap_after, input int gap_len, input logic fetch_too,
                      input string tag);
    fetch_exp_t e;
    bus.load_start   = 1'b1;
    bus.load_count   = AW'(count_req);
    bus.fetch_enable = fetch_too;
    bus.address      = '0;
    if (fetch_too) begin
      e.instr = NOP_W;
      e.valid = 1'b0;
      sb.push_back(e);
    end
    step();
    bus.load_start   = 1'b0;
    bus.fetch_enable = 1'b0;
    if (fetch_too) begin
      e = sb.pop_front();
      check({tag, "_win_instr"}, 32'(bus.instruction), 32'(e.instr));
      check({tag, "_win_valid"}, 32'(bus.instruction_valid), 32'(e.valid));
    end
    check({tag, "_len_clear"}, 32'(bus.program_length), 32'd0);
    for (int i = 0; i < n_beats; i++) begin
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          bus.load_valid = 1'b0;
          check({tag, "_gap_ready"}, 32'(bus.load_ready), 32'd1);
          step();
          check({tag, "_gap_done"}, 32'(bus.load_done), 32'd0);
        end
      end
      bus.load_valid = 1'b1;
      bus.load_data  = base + DW'(i);
      check({tag, "_ready"}, 32'(bus.load_ready), 32'd1);
      check({tag, "_early_done"}, 32'(bus.load_done), 32'd0);
      step();
    end
    bus.load_valid = 1'b0;
    check({tag, "_done"}, 32'(bus.load_done), 32'd1);
    check({tag, "_ready_off"}, 32'(bus.load_ready), 32'd0);
    check({tag, "_len"}, 32'(bus.program_length), 32'(n_beats));
    step();
    check({tag, "_done_pulse"}, 32'(bus.load_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.load_start   = 1'b0;
    bus.load_count   = '0;
    bus.load_valid   = 1'b0;
    bus.load_data    = '0;
    bus.fetch_enable = 1'b0;
    bus.address      = '0;

    // reset state
    step();
    step();
    check("rst_len",   32'(bus.program_length), 32'd0);
    check("rst_ready", 32'(bus.load_ready), 32'd0);
    check("rst_done",  32'(bus.load_done), 32'd0);
    check("rst_instr", 32'(bus.instruction), 32'(NOP_W));
    check("rst_valid", 32'(bus.instruction_valid), 32'd0);
    rst_n = 1'b1;
    step();

    // fetch in IDLE is gated
    fetch(1'b1, 16'd0, NOP_W, 1'b0, "idle_f0");
    fetch(1'b1, 16'd5, NOP_W, 1'b0, "idle_f5");
    check("idle_len", 32'(bus.program_length), 32'd0);

    // 4-word load with a 3-cycle gap after beat 2
    load(4, 4, 28'h1000001, 2, 3, 1'b0, "ld4");

    fetch(1'b1, 16'd0,   28'h1000001, 1'b1, "run_f0");
    fetch(1'b1, 16'd3,   28'h1000004, 1'b1, "run_f3");
    fetch(1'b1, 16'd4,   DEF_W,       1'b1, "run_f4");
    fetch(1'b1, 16'd300, DEF_W,       1'b1, "run_f300");
    fetch(1'b0, 16'd300, DEF_W,       1'b0, "hold_def");
    fetch(1'b1, 16'd3,   28'h1000004, 1'b1, "run_f3b");
    fetch(1'b0, 16'd0,   28'h1000004, 1'b0, "hold_ram");

    // zero-count start is ignored, fetch proceeds
    bus.load_start = 1'b1;
    bus.load_count = '0;
    fetch(1'b1, 16'd2, 28'h1000003, 1'b1, "zero_start_f2");
    bus.load_start = 1'b0;
    check("zero_start_ready", 32'(bus.load_ready), 32'd0);
    check("zero_start_len",   32'(bus.program_length), 32'd4);

    // oversize load clamps to DEPTH; simultaneous fetch loses to the load
    load(1000, DEPTH, 28'h0500000, -1, 0, 1'b1, "ld1000");
    fetch(1'b1, 16'd255, 28'h0500000 + 28'd255, 1'b1, "full_f255");
    fetch(1'b1, 16'd256, DEF_W,                 1'b1, "full_f256");
    fetch(1'b1, 16'd0,   28'h0500000,           1'b1, "full_f0");

    // reset mid-load hides partially written words
    bus.load_start = 1'b1;
    bus.load_count = 16'd8;
    step();
    bus.load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 28'h3000000 + DW'(i);
      step();
    end
    bus.load_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_len",   32'(bus.program_length), 32'd0);
    check("midrst_ready", 32'(bus.load_ready), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    load(1, 1, 28'h2000000, -1, 0, 1'b0, "ld1");
    fetch(1'b1, 16'd0, 28'h2000000, 1'b1, "after_rst_f0");
    fetch(1'b1, 16'd1, DEF_W,       1'b1, "after_rst_f1");

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
